bram_port_arbiter: RTL and testbench
====================================

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 SHALL have parameter LDR_BURST, default 4, meaning the maximum number of consecutive loader grants while the CPU is waiting; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port cpu_en_i, input, 1, CPU data request valid.
REQ-005 SHALL have port cpu_we_i, input, 4, CPU byte write enables; 0 means read.
REQ-006 SHALL have port cpu_addr_i, input, 32, CPU byte address.
REQ-007 SHALL have port cpu_data_i, input, 32, CPU write data.
REQ-008 SHALL have port cpu_data_o, output, 32, CPU read data.
REQ-009 SHALL have port cpu_stall_o, output, 1, CPU request not granted this cycle.
REQ-010 SHALL have port ld_req_i, input, 1, loader request valid.
REQ-011 SHALL have port ld_we_i, input, 4, loader byte write enables.
REQ-012 SHALL have port ld_addr_i, input, 32, loader byte address.
REQ-013 SHALL have port ld_data_i, input, 32, loader write data.
REQ-014 SHALL have port ld_gnt_o, output, 1, loader request accepted this cycle.
REQ-015 SHALL have port ld_rvalid_o, output, 1, loader read data valid.
REQ-016 SHALL have port ld_data_o, output, 32, loader read data.
REQ-017 SHALL have ports ram_en_o (output, 1), ram_we_o (output, 4), ram_addr_o (output, 32) and ram_data_o (output, 32), which drive the BRAM data port.
REQ-018 SHALL have port ram_data_i, input, 32, BRAM read data with 1-cycle latency.

Function
REQ-019 SHALL grant at most one requester per cycle; the grant is combinational from the current requests and the registered state.
REQ-020 SHALL grant the loader by default when both requesters are active, except as stated in REQ-022.
REQ-021 SHALL keep a burst counter, bcnt (4 bits): it increments on each loader grant made while cpu_en_i=1, and clears on any CPU grant or on any cycle with cpu_en_i=0.
REQ-022 SHALL grant the CPU when cpu_en_i=1 and bcnt==LDR_BURST, regardless of ld_req_i.
REQ-023 SHALL grant a single active requester unconditionally.
REQ-024 SHALL, for the granted requester, drive ram_en_o=1 and forward its we, addr and data unchanged to the ram_* outputs.
REQ-025 SHALL, with no grant, drive ram_en_o=0, ram_we_o=0, ram_addr_o=0 and ram_data_o=0.
REQ-026 SHALL assert cpu_stall_o = cpu_en_i AND NOT cpu_grant.
REQ-027 SHALL assert ld_gnt_o = ld_req_i AND loader_grant.
REQ-028 SHALL require the CPU to hold its request stable while stalled; the loader holds its request until ld_gnt_o=1.
REQ-029 SHALL keep a read-owner register with 2-bit state NONE, CPU or LDR, which records which requester, if any, was granted a read (we==0) in the previous cycle.
REQ-030 SHALL update the read-owner register every cycle: a granted write or no grant sets NONE.
REQ-031 SHALL drive ld_rvalid_o=1 exactly one cycle after a loader read grant, i.e. when owner==LDR.
REQ-032 SHALL drive ld_data_o = ram_data_i when owner==LDR and 0 otherwise.
REQ-033 SHALL drive cpu_data_o = ram_data_i when owner==CPU and hold the last CPU read value otherwise (registered hold); the hold resets to 0.
REQ-034 SHALL produce ld_rvalid_o=0 for loader writes.
REQ-035 SHALL permit back-to-back reads from alternating owners, each returned to its owner on consecutive cycles.

Reset
REQ-036 SHALL, with reset=1 at a clock edge, clear bcnt to 0, owner to NONE, the CPU hold register to 0, and ld_rvalid_o to 0.
REQ-037 SHALL, during the reset cycle, force ram_en_o=0, cpu_stall_o=0 and ld_gnt_o=0 regardless of requests.
REQ-038 SHALL discard an in-flight read when reset is asserted mid-operation: no ld_rvalid_o pulse follows reset.

Verification
REQ-039 SHALL cover: CPU alone reads 0x0000_0100 with RAM returning 0xDEAD_BEEF -> ram_en_o=1 and cpu_stall_o=0 in cycle 0, cpu_data_o=0xDEAD_BEEF in cycle 1, held in cycle 2 with no request.
REQ-040 SHALL cover: loader writes 0x0000_0200 with we=0xF while CPU idle -> ld_gnt_o=1, ram_we_o=0xF, ld_rvalid_o=0 in the next cycle.
REQ-041 SHALL cover: both requesting continuously with LDR_BURST=4 -> grant pattern L,L,L,L,C,L,L,L,L,C; cpu_stall_o=1 in exactly the L cycles.
REQ-042 SHALL cover: loader read at cycle 0, then CPU read at cycle 1 -> ld_rvalid_o=1 with ld_data_o=RAM word at cycle 1; cpu_data_o=RAM word at cycle 2; ld_rvalid_o=0 at cycle 2.
REQ-043 SHALL cover: loader read granted, then reset=1 in the next cycle -> ld_rvalid_o=0, ram_en_o=0, and bcnt=0 after the edge.
REQ-044 SHALL cover: cpu_en_i dropping for one cycle during a loader burst -> bcnt clears, and the CPU waits a further full 4 loader grants after re-requesting.

Source files
------------

// File: rtl/bram_port_arbiter_if.sv
// Bundles the CPU, loader and BRAM data-port signals of the arbiter.
// The slave modport is the arbiter; the master modport is everything around it.
interface bram_port_arbiter_if;
   logic        cpu_en_i;
   logic [3:0]  cpu_we_i;
   logic [31:0] cpu_addr_i;
   logic [31:0] cpu_data_i;
   logic [31:0] cpu_data_o;
   logic        cpu_stall_o;

   logic        ld_req_i;
   logic [3:0]  ld_we_i;
   logic [31:0] ld_addr_i;
   logic [31:0] ld_data_i;
   logic        ld_gnt_o;
   logic        ld_rvalid_o;
   logic [31:0] ld_data_o;

   logic        ram_en_o;
   logic [3:0]  ram_we_o;
   logic [31:0] ram_addr_o;
   logic [31:0] ram_data_o;
   logic [31:0] ram_data_i;

   modport slave (
      input  cpu_en_i, cpu_we_i, cpu_addr_i, cpu_data_i,
      output cpu_data_o, cpu_stall_o,
      input  ld_req_i, ld_we_i, ld_addr_i, ld_data_i,
      output ld_gnt_o, ld_rvalid_o, ld_data_o,
      output ram_en_o, ram_we_o, ram_addr_o, ram_data_o,
      input  ram_data_i
   );

   modport master (
      output cpu_en_i, cpu_we_i, cpu_addr_i, cpu_data_i,
      input  cpu_data_o, cpu_stall_o,
      output ld_req_i, ld_we_i, ld_addr_i, ld_data_i,
      input  ld_gnt_o, ld_rvalid_o, ld_data_o,
      input  ram_en_o, ram_we_o, ram_addr_o, ram_data_o,
      output ram_data_i
   );
endinterface

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM data port between a CPU and a loader; loader wins ties
// until it has taken LDR_BURST grants while the CPU waits.
//
// owner state | meaning
// OWN_NONE    | no read issued last cycle (idle or write)
// OWN_CPU     | CPU read issued last cycle, RAM data belongs to CPU
// OWN_LDR     | loader read issued last cycle, RAM data belongs to loader
module bram_port_arbiter #(
   parameter int unsigned LDR_BURST = 4
) (
   input logic                 clk,
   input logic                 reset,
   bram_port_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_LDR  = 2'd2
   } owner_e;

   localparam logic [3:0] BURST = 4'(LDR_BURST);

   owner_e      owner_q, owner_d;
   logic [3:0]  bcnt_q, bcnt_d;
   logic [31:0] cpu_hold_q, cpu_hold_d;
   logic        cpu_gnt, ld_gnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q    <= OWN_NONE;
         bcnt_q     <= 4'd0;
         cpu_hold_q <= 32'd0;
      end else begin
         owner_q    <= owner_d;
         bcnt_q     <= bcnt_d;
         cpu_hold_q <= cpu_hold_d;
      end
   end

   always_comb begin
      cpu_gnt        = 1'b0;
      ld_gnt         = 1'b0;
      bcnt_d         = bcnt_q;
      owner_d        = OWN_NONE;
      bus.ram_en_o   = 1'b0;
      bus.ram_we_o   = 4'h0;
      bus.ram_addr_o = 32'd0;
      bus.ram_data_o = 32'd0;

      // Reset masks every grant so the RAM port stays quiet during the reset cycle.
      if (!reset) begin
         if (bus.cpu_en_i && (!bus.ld_req_i || bcnt_q == BURST)) begin
            cpu_gnt = 1'b1;
         end else if (bus.ld_req_i) begin
            ld_gnt = 1'b1;
         end
      end

      if (cpu_gnt || !bus.cpu_en_i) begin
         bcnt_d = 4'd0;
      end else if (ld_gnt) begin
         bcnt_d = bcnt_q + 4'd1;
      end

      if (cpu_gnt) begin
         bus.ram_en_o   = 1'b1;
         bus.ram_we_o   = bus.cpu_we_i;
         bus.ram_addr_o = bus.cpu_addr_i;
         bus.ram_data_o = bus.cpu_data_i;
         owner_d        = (bus.cpu_we_i == 4'h0) ? OWN_CPU : OWN_NONE;
      end else if (ld_gnt) begin
         bus.ram_en_o   = 1'b1;
         bus.ram_we_o   = bus.ld_we_i;
         bus.ram_addr_o = bus.ld_addr_i;
         bus.ram_data_o = bus.ld_data_i;
         owner_d        = (bus.ld_we_i == 4'h0) ? OWN_LDR : OWN_NONE;
      end

      bus.cpu_stall_o = bus.cpu_en_i && !cpu_gnt && !reset;
      bus.ld_gnt_o    = bus.ld_req_i && ld_gnt;

      // A loader read in flight when reset arrives is dropped, not returned.
      bus.ld_rvalid_o = (owner_q == OWN_LDR) && !reset;
      bus.ld_data_o   = bus.ld_rvalid_o ? bus.ram_data_i : 32'd0;

      bus.cpu_data_o  = (owner_q == OWN_CPU) ? bus.ram_data_i : cpu_hold_q;
      cpu_hold_d      = bus.cpu_data_o;
   end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: scenario tasks plus a read-data
// scoreboard that matches returned words to the requester that issued them.
module tb_bram_port_arbiter;

   localparam int unsigned LB = 4;

   logic clk = 1'b0;
   logic reset;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   bit   mon_en   = 1'b0;

   typedef struct {
      bit          is_ld;
      logic [31:0] data;
      int          due;
   } sb_item_t;

   sb_item_t    sb_q[$];
   sb_item_t    it;
   bit          ld_due;
   logic [31:0] ram_rd = 32'd0;

   bram_port_arbiter_if bus ();

   bram_port_arbiter #(.LDR_BURST(LB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
      return {a[15:0] ^ 16'h5A5A, a[15:0]};
   endfunction

   // BRAM model: one-cycle read latency.
   always @(posedge clk)
      if (bus.ram_en_o && bus.ram_we_o == 4'h0) ram_rd <= mem_fn(bus.ram_addr_o);
   assign bus.ram_data_i = ram_rd;

   // Scoreboard: pop reads due this cycle and compare against the owner's output.
   always @(negedge clk) begin
      if (mon_en) begin
         ld_due = 1'b0;
         while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            it = sb_q.pop_front();
            n_assert++;
            if (it.due != cyc) begin
               n_fail++;
               $display("FAIL sb_late: item due %0d still queued at %0d", it.due, cyc);
            end else if (it.is_ld) begin
               ld_due = 1'b1;
               if (bus.ld_rvalid_o !== 1'b1 || bus.ld_data_o !== it.data) begin
                  n_fail++;
                  $display("FAIL sb_ld_read: rvalid=%b data=%h, required rvalid=1 data=%h",
                           bus.ld_rvalid_o, bus.ld_data_o, it.data);
               end
            end else if (bus.cpu_data_o !== it.data) begin
               n_fail++;
               $display("FAIL sb_cpu_read: cpu_data_o=%h, required %h", bus.cpu_data_o, it.data);
            end
         end
         if (!ld_due) begin
            n_assert++;
            if (bus.ld_rvalid_o !== 1'b0) begin
               n_fail++;
               $display("FAIL sb_no_rvalid: ld_rvalid_o=%b at cycle %0d, required 0",
                        bus.ld_rvalid_o, cyc);
            end
         end
      end
   end

   task automatic drive(input bit c_en, input logic [3:0] c_we, input logic [31:0] c_addr,
                        input logic [31:0] c_data, input bit l_req, input logic [3:0] l_we,
                        input logic [31:0] l_addr, input logic [31:0] l_data);
      bus.cpu_en_i   = c_en;
      bus.cpu_we_i   = c_we;
      bus.cpu_addr_i = c_addr;
      bus.cpu_data_i = c_data;
      bus.ld_req_i   = l_req;
      bus.ld_we_i    = l_we;
      bus.ld_addr_i  = l_addr;
      bus.ld_data_i  = l_data;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic push_read(input bit is_ld, input logic [31:0] addr);
      sb_item_t n;
      n.is_ld = is_ld;
      n.data  = mem_fn(addr);
      n.due   = cyc + 1;
      sb_q.push_back(n);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1, 4'h0, 32'h10, 0, 1, 4'h0, 32'h20, 0);
      @(negedge clk);
      n_assert++;
      if (bus.ram_en_o !== 1'b0 || bus.cpu_stall_o !== 1'b0 || bus.ld_gnt_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_force: en=%b stall=%b gnt=%b, required 0 0 0",
                  bus.ram_en_o, bus.cpu_stall_o, bus.ld_gnt_o);
      end
      n_assert++;
      if (dut.bcnt_q !== 4'd0 || bus.cpu_data_o !== 32'd0 || bus.ld_rvalid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: bcnt=%h cpu_data=%h rvalid=%b, required 0 0 0",
                  dut.bcnt_q, bus.cpu_data_o, bus.ld_rvalid_o);
      end
      next_cycle();
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      mon_en = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_cpu_read();
      next_cycle();
      drive(1, 4'h0, 32'h0000_0100, 0, 0, 0, 0, 0);
      @(negedge clk);
      n_assert++;
      if (bus.ram_en_o !== 1'b1 || bus.cpu_stall_o !== 1'b0 || bus.ram_addr_o !== 32'h100) begin
         n_fail++;
         $display("FAIL cpu_read_issue: en=%b stall=%b addr=%h, required 1 0 00000100",
                  bus.ram_en_o, bus.cpu_stall_o, bus.ram_addr_o);
      end
      push_read(0, 32'h0000_0100);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      next_cycle();
      @(negedge clk);
      n_assert++;
      if (bus.cpu_data_o !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL cpu_read_hold: cpu_data_o=%h, required deadbeef", bus.cpu_data_o);
      end
   endtask

   task automatic test_ld_write();
      next_cycle();
      drive(0, 0, 0, 0, 1, 4'hF, 32'h0000_0200, 32'h1234_5678);
      @(negedge clk);
      n_assert++;
      if (bus.ld_gnt_o !== 1'b1 || bus.ram_we_o !== 4'hF || bus.ram_addr_o !== 32'h200 ||
          bus.ram_data_o !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL ld_write: gnt=%b we=%h addr=%h data=%h, required 1 f 00000200 12345678",
                  bus.ld_gnt_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_data_o);
      end
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      n_assert++;
      if (bus.ld_rvalid_o !== 1'b0 || bus.ram_en_o !== 1'b0 || bus.ram_addr_o !== 32'd0) begin
         n_fail++;
         $display("FAIL ld_write_after: rvalid=%b en=%b addr=%h, required 0 0 0",
                  bus.ld_rvalid_o, bus.ram_en_o, bus.ram_addr_o);
      end
   endtask

   task automatic test_burst();
      logic [9:0]  pat;
      logic [31:0] l_addr;
      bit          c;
      pat    = 10'b10_0001_0000;
      l_addr = 32'h0000_0400;
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         drive(1, 4'h0, 32'h0000_0300, 0, 1, 4'h0, l_addr, 0);
         @(negedge clk);
         c = pat[i];
         n_assert++;
         if (bus.cpu_stall_o !== !c || bus.ld_gnt_o !== !c ||
             bus.ram_addr_o !== (c ? 32'h300 : l_addr)) begin
            n_fail++;
            $display("FAIL burst_grant[%0d]: stall=%b gnt=%b addr=%h, required %b %b %h",
                     i, bus.cpu_stall_o, bus.ld_gnt_o, bus.ram_addr_o, !c, !c,
                     c ? 32'h300 : l_addr);
         end
         if (c) push_read(0, 32'h0000_0300);
         else begin
            push_read(1, l_addr);
            l_addr = l_addr + 32'd4;
         end
      end
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
   endtask

   task automatic test_alt_reads();
      next_cycle();
      drive(0, 0, 0, 0, 1, 4'h0, 32'h0000_0500, 0);
      @(negedge clk);
      push_read(1, 32'h0000_0500);
      next_cycle();
      drive(1, 4'h0, 32'h0000_0600, 0, 0, 0, 0, 0);
      @(negedge clk);
      push_read(0, 32'h0000_0600);
      n_assert++;
      if (bus.cpu_stall_o !== 1'b0 || bus.ram_addr_o !== 32'h600) begin
         n_fail++;
         $display("FAIL alt_cpu_issue: stall=%b addr=%h, required 0 00000600",
                  bus.cpu_stall_o, bus.ram_addr_o);
      end
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      n_assert++;
      if (bus.ld_rvalid_o !== 1'b0 || bus.cpu_data_o !== mem_fn(32'h600)) begin
         n_fail++;
         $display("FAIL alt_second: rvalid=%b cpu_data=%h, required 0 %h",
                  bus.ld_rvalid_o, bus.cpu_data_o, mem_fn(32'h600));
      end
   endtask

   task automatic test_reset_midread();
      next_cycle();
      drive(1, 4'h0, 32'h0000_0900, 0, 1, 4'h0, 32'h0000_0700, 0);
      @(negedge clk);
      n_assert++;
      if (bus.ld_gnt_o !== 1'b1 || bus.cpu_stall_o !== 1'b1) begin
         n_fail++;
         $display("FAIL midread_issue: gnt=%b stall=%b, required 1 1", bus.ld_gnt_o, bus.cpu_stall_o);
      end
      next_cycle();
      reset = 1'b1;
      @(negedge clk);
      n_assert++;
      if (bus.ld_rvalid_o !== 1'b0 || bus.ram_en_o !== 1'b0 || bus.cpu_stall_o !== 1'b0 ||
          bus.ld_gnt_o !== 1'b0) begin
         n_fail++;
         $display("FAIL midread_reset: rvalid=%b en=%b stall=%b gnt=%b, required 0 0 0 0",
                  bus.ld_rvalid_o, bus.ram_en_o, bus.cpu_stall_o, bus.ld_gnt_o);
      end
      next_cycle();
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      n_assert++;
      if (dut.bcnt_q !== 4'd0 || bus.ld_rvalid_o !== 1'b0 || bus.cpu_data_o !== 32'd0) begin
         n_fail++;
         $display("FAIL midread_after: bcnt=%h rvalid=%b cpu_data=%h, required 0 0 0",
                  dut.bcnt_q, bus.ld_rvalid_o, bus.cpu_data_o);
      end
   endtask

   task automatic test_cpu_drop();
      logic [7:0] en_pat;
      logic [7:0] c_pat;
      bit         e, c;
      en_pat = 8'b1111_1011;
      c_pat  = 8'b1000_0000;
      for (int i = 0; i < 8; i++) begin
         e = en_pat[i];
         c = c_pat[i];
         next_cycle();
         drive(e, 4'h0, 32'h0000_0800, 0, 1, 4'hF, 32'h0000_0A00 + 32'(i), 32'(i));
         @(negedge clk);
         n_assert++;
         if (bus.cpu_stall_o !== (e && !c) || bus.ld_gnt_o !== !c) begin
            n_fail++;
            $display("FAIL drop_grant[%0d]: stall=%b gnt=%b, required %b %b",
                     i, bus.cpu_stall_o, bus.ld_gnt_o, e && !c, !c);
         end
         if (i == 3) begin
            n_assert++;
            if (dut.bcnt_q !== 4'd0) begin
               n_fail++;
               $display("FAIL drop_bcnt_clear: bcnt=%h, required 0", dut.bcnt_q);
            end
         end
         if (c) push_read(0, 32'h0000_0800);
      end
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_cpu_read();
      test_ld_write();
      test_burst();
      test_alt_reads();
      test_reset_midread();
      test_cpu_drop();
      next_cycle();
      @(negedge clk);
      n_assert++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d reads never returned, required 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
